// File: rtl/sp_dec_2.sv
// Stack-pointer unit: word-aligned SP with push (-2) / pop (+2), full/empty/depth decode,
// and an overflow/underflow FAULT state that only a load (or reset) clears.
module sp_dec_2 #(
  parameter int unsigned          WIDTH    = 16,
  parameter logic [WIDTH-1:0]     SP_TOP   = 16'hFFFE,
  parameter logic [WIDTH-1:0]     SP_LIMIT = 16'hF000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             push,
  input  logic             pop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] sp,
  output logic [WIDTH-1:0] sp_next,
  output logic [WIDTH-2:0] depth,
  output logic             full,
  output logic             empty,
  output logic             fault,
  output logic             state_dbg
);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] occupied_bytes;

  // Handshake: push/pop/load are single-cycle requests, sampled at every rising edge
  // with no ready back-pressure; a stall cycle drops them, it does not queue them.
  assign full           = (sp_q == SP_LIMIT);
  assign empty          = (sp_q == SP_TOP);
  assign occupied_bytes = SP_TOP - sp_q;
  assign depth          = occupied_bytes[WIDTH-1:1];

  always_comb begin
    sp_d    = sp_q;
    state_d = state_q;
    if (rst) begin
      sp_d    = SP_TOP;
      state_d = RUN;
    end else if (!stall) begin
      if (load) begin
        sp_d    = {load_val[WIDTH-1:1], 1'b0};
        state_d = RUN;
      end else if (state_q == RUN) begin
        if (push && !pop) begin
          if (full) state_d = FAULT;
          else      sp_d    = sp_q - WIDTH'(2);
        end else if (pop && !push) begin
          if (empty) state_d = FAULT;
          else       sp_d    = sp_q + WIDTH'(2);
        end
      end
    end
  end

  // rst is already folded into the _d terms so sp_next reports the reset value too.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    sp_q    <= sp_d;
  end

  assign sp        = sp_q;
  assign sp_next   = sp_d;
  assign fault     = (state_q == FAULT);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sp_dec_2.sv
// Bench for sp_dec_2: directed vector table followed by randomized traffic checked
// against an integer-arithmetic stack model.
module tb_sp_dec_2;

  logic        clk = 1'b0;
  logic        rst, stall, push, pop, load;
  logic [15:0] load_val;
  logic [15:0] sp, sp_next;
  logic [14:0] depth;
  logic        full, empty, fault, state_dbg;

  int total = 0;
  int bad   = 0;

  // model state
  int m_sp;
  bit m_fault;
  int n_sp;
  bit n_fault;

  logic [15:0] exp_q[$];

  sp_dec_2 dut (
    .clk(clk), .rst(rst), .stall(stall), .push(push), .pop(pop), .load(load),
    .load_val(load_val), .sp(sp), .sp_next(sp_next), .depth(depth),
    .full(full), .empty(empty), .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, push, pop, load;
    logic [15:0] load_val;
    logic [15:0] exp_sp;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stack model: SP counts down in 2-byte words between 0xFFFE (empty) and 0xF000 (full).
  task automatic model_next(input logic r, s, pu, po, ld, input logic [15:0] lv);
    n_sp = m_sp;
    n_fault = m_fault;
    if (r) begin
      n_sp = 'hFFFE; n_fault = 0;
    end else if (s) begin
      // hold
    end else if (ld) begin
      n_sp = lv & 'hFFFE; n_fault = 0;
    end else if (!m_fault && pu != po) begin
      if (pu && m_sp == 'hF000)      n_fault = 1;
      else if (po && m_sp == 'hFFFE) n_fault = 1;
      else n_sp = (m_sp + (pu ? -2 : 2)) & 'hFFFF;
    end
  endtask

  task automatic apply(input logic r, s, pu, po, ld, input logic [15:0] lv);
    rst = r; stall = s; push = pu; pop = po; load = ld; load_val = lv;
    #1;
    model_next(r, s, pu, po, ld, lv);
    exp_q.push_back(n_sp[15:0]);
    check("sp_next", sp_next, n_sp);
    @(posedge clk);
    m_sp = n_sp;
    m_fault = n_fault;
    #1;
    check("sp", sp, exp_q.pop_front());
    check("fault", fault, m_fault);
    check("state_dbg", state_dbg, m_fault);
    check("depth", depth, ((('hFFFE - m_sp) & 'hFFFF) >> 1));
    check("full", full, m_sp == 'hF000);
    check("empty", empty, m_sp == 'hFFFE);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic r, s, pu, po, ld, input logic [15:0] lv,
                              input logic [15:0] esp, input logic ef);
    vec_t v;
    v.rst = r; v.stall = s; v.push = pu; v.pop = po; v.load = ld;
    v.load_val = lv; v.exp_sp = esp; v.exp_fault = ef;
    return v;
  endfunction

  initial begin
    // directed sequence: rst stall push pop load load_val | exp_sp exp_fault
    vecs.push_back(mk(1,0,0,0,0,16'h0000, 16'hFFFE,0)); // reset
    vecs.push_back(mk(0,0,1,0,0,16'h0000, 16'hFFFC,0));
    vecs.push_back(mk(0,0,1,0,0,16'h0000, 16'hFFFA,0));
    vecs.push_back(mk(0,0,1,0,0,16'h0000, 16'hFFF8,0)); // depth 3
    vecs.push_back(mk(0,0,0,1,0,16'h0000, 16'hFFFA,0));
    vecs.push_back(mk(1,0,0,0,0,16'h0000, 16'hFFFE,0));
    vecs.push_back(mk(0,0,0,1,0,16'h0000, 16'hFFFE,1)); // underflow
    vecs.push_back(mk(0,0,1,0,0,16'h0000, 16'hFFFE,1)); // ignored in fault
    vecs.push_back(mk(0,0,0,0,1,16'h8001, 16'h8000,0)); // load clears fault
    vecs.push_back(mk(0,0,0,0,1,16'hF002, 16'hF002,0));
    vecs.push_back(mk(0,0,1,0,0,16'h0000, 16'hF000,0)); // full
    vecs.push_back(mk(0,0,1,0,0,16'h0000, 16'hF000,1)); // overflow
    vecs.push_back(mk(0,0,1,1,1,16'hF000, 16'hF000,0)); // load beats push/pop
    vecs.push_back(mk(0,0,1,1,0,16'h0000, 16'hF000,0)); // replace-top at full
    vecs.push_back(mk(1,0,0,0,0,16'h0000, 16'hFFFE,0));
    vecs.push_back(mk(0,0,1,1,0,16'h0000, 16'hFFFE,0)); // replace-top at empty
    vecs.push_back(mk(0,1,1,0,0,16'h0000, 16'hFFFE,0)); // stalled push
    vecs.push_back(mk(0,1,1,0,1,16'h1234, 16'hFFFE,0)); // stall beats load
    vecs.push_back(mk(0,0,1,0,0,16'h0000, 16'hFFFC,0));
    vecs.push_back(mk(1,0,1,0,0,16'h0000, 16'hFFFE,0)); // rst beats push
    vecs.push_back(mk(0,0,0,1,0,16'h0000, 16'hFFFE,1));
    vecs.push_back(mk(0,1,0,0,1,16'h4444, 16'hFFFE,1)); // stalled in fault
    vecs.push_back(mk(1,1,0,0,0,16'h0000, 16'hFFFE,0)); // rst beats stall, clears fault
    vecs.push_back(mk(0,0,0,0,1,16'h0003, 16'h0002,0)); // out-of-range load
    vecs.push_back(mk(0,0,1,0,0,16'h0000, 16'h0000,0));
    vecs.push_back(mk(0,0,1,0,0,16'h0000, 16'hFFFE,0)); // wraps mod 2^16

    rst = 1; stall = 0; push = 0; pop = 0; load = 0; load_val = '0;
    m_sp = 'hFFFE; m_fault = 0;
    @(negedge clk);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].stall, vecs[i].push, vecs[i].pop, vecs[i].load,
            vecs[i].load_val);
      check($sformatf("vec%0d_sp", i), sp, vecs[i].exp_sp);
      check($sformatf("vec%0d_fault", i), fault, vecs[i].exp_fault);
    end

    // hand-written: depth after three pushes from reset, sp_next during stall
    apply(1,0,0,0,0,16'h0);
    for (int k = 0; k < 3; k++) apply(0,0,1,0,0,16'h0);
    check("depth3", depth, 3);
    stall = 1; push = 1; #1;
    check("stall_sp_next", sp_next, 16'hFFF8);

    @(negedge clk);
    for (int k = 0; k < 600; k++) begin
      logic        r, s, pu, po, ld;
      logic [15:0] lv;
      r  = ($urandom_range(0, 59) == 0);
      s  = ($urandom_range(0, 7) == 0);
      ld = ($urandom_range(0, 11) == 0);
      pu = $urandom_range(0, 1);
      po = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0:       lv = 16'hF000 + 16'($urandom_range(0, 9));
        1:       lv = 16'hFFFE - 16'($urandom_range(0, 9));
        default: lv = 16'($urandom);
      endcase
      apply(r, s, pu, po, ld, lv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded expected 0");
    $fatal(1, "timeout");
  end

endmodule
